// File: rtl/rca_pkg.sv
// Shared constants and the pipeline stage record for the pipelined ripple-carry adder.
// Operand/sum fields are sized for the widest supported build; narrower builds use the low bits.
package rca_pkg;

    localparam int RCA_DEFAULT_WIDTH  = 16;
    localparam int RCA_DEFAULT_STAGES = 4;
    localparam int RCA_MAX_WIDTH      = 64;

    typedef struct packed {
        logic                     valid;
        logic                     carry;
        logic [RCA_MAX_WIDTH-1:0] sum;
        logic [RCA_MAX_WIDTH-1:0] a;
        logic [RCA_MAX_WIDTH-1:0] b;
    } stage_t;

endpackage

// File: rtl/rca_slice.sv
// Combinational CHUNK-bit adder built as a ripple of full-adder bits.
module rca_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    logic c;

    always_comb begin
        s = '0;
        c = ci;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder: stage i adds chunk i with the carry registered by stage i-1.
// Define PIPELINED_RCA_OVF_EN to add the OVF (signed overflow) output aligned with S.
module pipelined_rca
    import rca_pkg::*;
#(
    parameter int WIDTH  = RCA_DEFAULT_WIDTH,
    parameter int STAGES = RCA_DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             out_valid,
    input  logic             out_ready
`ifdef PIPELINED_RCA_OVF_EN
    ,
    output logic             OVF
`endif
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    if ((WIDTH % STAGES) != 0) begin : g_bad_split
        $fatal(1, "pipelined_rca: WIDTH (%0d) is not divisible by STAGES (%0d)", WIDTH, STAGES);
    end
    if (WIDTH > RCA_MAX_WIDTH) begin : g_bad_width
        $fatal(1, "pipelined_rca: WIDTH (%0d) exceeds RCA_MAX_WIDTH (%0d)", WIDTH, RCA_MAX_WIDTH);
    end

    stage_t           feed    [STAGES];
    stage_t           stage_d [STAGES];
    stage_t           stage_q [STAGES];
    logic [CHUNK-1:0] s_chunk [STAGES];
    logic             co      [STAGES];
    logic             adv;

    assign adv      = !stage_q[LAST].valid || out_ready;
    assign in_ready = adv;

    // feed[i] is what stage i consumes: the port operands for stage 0, the previous register otherwise.
    always_comb begin
        feed[0].valid = in_valid;
        feed[0].carry = Cin;
        feed[0].sum   = '0;
        feed[0].a     = RCA_MAX_WIDTH'(A);
        feed[0].b     = RCA_MAX_WIDTH'(B);
        for (int unsigned i = 1; i < STAGES; i++) begin
            feed[i] = stage_q[i-1];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        rca_slice #(.CHUNK(CHUNK)) u_slice (
            .a  (feed[g].a[CHUNK-1:0]),
            .b  (feed[g].b[CHUNK-1:0]),
            .ci (feed[g].carry),
            .s  (s_chunk[g]),
            .co (co[g])
        );
    end

    // Pending operand chunks shift down so every slice works on the low CHUNK bits.
    always_comb begin
        for (int unsigned i = 0; i < STAGES; i++) begin
            stage_d[i] = stage_q[i];
            if (adv) begin
                stage_d[i].valid = feed[i].valid;
                stage_d[i].carry = co[i];
                stage_d[i].sum   = feed[i].sum | (RCA_MAX_WIDTH'(s_chunk[i]) << (i * CHUNK));
                stage_d[i].a     = feed[i].a >> CHUNK;
                stage_d[i].b     = feed[i].b >> CHUNK;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign S         = stage_q[LAST].sum[WIDTH-1:0];
    assign Cout      = stage_q[LAST].carry;
    assign out_valid = stage_q[LAST].valid;

`ifdef PIPELINED_RCA_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // Signed overflow is the carry out of the MSB xor the carry into it (a^b^s at the MSB).
    always_comb begin
        ovf_d = ovf_q;
        if (adv) begin
            ovf_d = co[LAST] ^ feed[LAST].a[CHUNK-1] ^ feed[LAST].b[CHUNK-1]
                  ^ s_chunk[LAST][CHUNK-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign OVF = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_rca.sv
// Directed self-checking bench for pipelined_rca: a 16-bit/4-stage instance plus
// 4-bit instances with 1, 2 and 4 stages that are swept exhaustively.
module tb_pipelined_rca;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] a, b;
    logic        cin, in_valid, in_ready, out_ready;
    logic [15:0] s;
    logic        cout, out_valid;

    logic [3:0]  na, nb;
    logic        ncin, n_valid;
    logic [3:0]  n1_s, n2_s, n4_s;
    logic        n1_co, n2_co, n4_co;
    logic        n1_ov, n2_ov, n4_ov;
    logic        n1_ir, n2_ir, n4_ir;

`ifdef PIPELINED_RCA_OVF_EN
    logic ovf, n1_ovf, n2_ovf, n4_ovf;
`endif

    int nvec = 0;
    int nerr = 0;

    logic [15:0] va [13];
    logic [15:0] vb [13];
    logic        vc [13];
    logic [16:0] ve [13];

    always #5 clk = ~clk;

    pipelined_rca #(.WIDTH(16), .STAGES(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .A(a), .B(b), .Cin(cin), .in_valid(in_valid),
        .in_ready(in_ready), .S(s), .Cout(cout), .out_valid(out_valid), .out_ready(out_ready)
`ifdef PIPELINED_RCA_OVF_EN
        , .OVF(ovf)
`endif
    );

    pipelined_rca #(.WIDTH(4), .STAGES(1)) u_n1 (
        .clk(clk), .rst_n(rst_n), .A(na), .B(nb), .Cin(ncin), .in_valid(n_valid),
        .in_ready(n1_ir), .S(n1_s), .Cout(n1_co), .out_valid(n1_ov), .out_ready(1'b1)
`ifdef PIPELINED_RCA_OVF_EN
        , .OVF(n1_ovf)
`endif
    );

    pipelined_rca #(.WIDTH(4), .STAGES(2)) u_n2 (
        .clk(clk), .rst_n(rst_n), .A(na), .B(nb), .Cin(ncin), .in_valid(n_valid),
        .in_ready(n2_ir), .S(n2_s), .Cout(n2_co), .out_valid(n2_ov), .out_ready(1'b1)
`ifdef PIPELINED_RCA_OVF_EN
        , .OVF(n2_ovf)
`endif
    );

    pipelined_rca #(.WIDTH(4), .STAGES(4)) u_n4 (
        .clk(clk), .rst_n(rst_n), .A(na), .B(nb), .Cin(ncin), .in_valid(n_valid),
        .in_ready(n4_ir), .S(n4_s), .Cout(n4_co), .out_valid(n4_ov), .out_ready(1'b1)
`ifdef PIPELINED_RCA_OVF_EN
        , .OVF(n4_ovf)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k);
        a        = va[k];
        b        = vb[k];
        cin      = vc[k];
        in_valid = 1'b1;
    endtask

    // Packs {out_valid, Cout, S} so one comparison covers the whole result.
    function automatic logic [31:0] res();
        return {14'd0, out_valid, cout, s};
    endfunction

    function automatic logic [31:0] want(input int k);
        return {14'd0, 1'b1, ve[k]};
    endfunction

    initial begin
        // 0..7: streaming set; 8..12: stall set
        va[0] = 16'h0000; vb[0] = 16'h0000; vc[0] = 1'b0; ve[0] = 17'h0_0000;
        va[1] = 16'h0001; vb[1] = 16'h0001; vc[1] = 1'b1; ve[1] = 17'h0_0003;
        va[2] = 16'h1234; vb[2] = 16'h4321; vc[2] = 1'b0; ve[2] = 17'h0_5555;
        va[3] = 16'hFFFF; vb[3] = 16'hFFFF; vc[3] = 1'b1; ve[3] = 17'h1_FFFF;
        va[4] = 16'h8000; vb[4] = 16'h8000; vc[4] = 1'b0; ve[4] = 17'h1_0000;
        va[5] = 16'h00FF; vb[5] = 16'h0001; vc[5] = 1'b0; ve[5] = 17'h0_0100;
        va[6] = 16'h0FFF; vb[6] = 16'h0000; vc[6] = 1'b1; ve[6] = 17'h0_1000;
        va[7] = 16'hABCD; vb[7] = 16'h5432; vc[7] = 1'b1; ve[7] = 17'h1_0000;
        va[8] = 16'h1111; vb[8] = 16'h2222; vc[8] = 1'b0; ve[8] = 17'h0_3333;
        va[9] = 16'hF000; vb[9] = 16'h1000; vc[9] = 1'b0; ve[9] = 17'h1_0000;
        va[10] = 16'h0F0F; vb[10] = 16'hF0F0; vc[10] = 1'b1; ve[10] = 17'h1_0000;
        va[11] = 16'h7FFF; vb[11] = 16'h0001; vc[11] = 1'b0; ve[11] = 17'h0_8000;
        va[12] = 16'h0005; vb[12] = 16'h0007; vc[12] = 1'b1; ve[12] = 17'h0_000D;

        rst_n = 1'b0; a = '0; b = '0; cin = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        na = '0; nb = '0; ncin = 1'b0; n_valid = 1'b0;

        // Reset state
        #12;
        chk("reset_result", res(), 32'h0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_narrow", {n1_ov, n2_ov, n4_ov, n1_s, n2_s, n4_s, n1_co, n2_co, n4_co},
            {3'b000, 12'h000, 3'b000});
        chk("reset_narrow_ready", {n1_ir, n2_ir, n4_ir}, 3'b111);
`ifdef PIPELINED_RCA_OVF_EN
        chk("reset_ovf", {31'd0, ovf}, 32'd0);
`endif
        rst_n = 1'b1;

        // FFFF + 0001: valid exactly on the 4th edge counting the accepting edge
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
        chk("lat_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("lat_edge1", {31'd0, out_valid}, 32'd0);
        tick();
        chk("lat_edge2", {31'd0, out_valid}, 32'd0);
        tick();
        chk("lat_edge3", {31'd0, out_valid}, 32'd0);
        tick();
        chk("lat_edge4", res(), {14'd0, 1'b1, 1'b1, 16'h0000});
        tick();
        chk("lat_bubble", {31'd0, out_valid}, 32'd0);

        // 8 back-to-back sets, one result per cycle in order
        for (int k = 0; k < 12; k++) begin
            if (k < 8) drive(k);
            else in_valid = 1'b0;
            tick();
            if (k >= 3 && k < 11) chk($sformatf("stream_%0d", k - 3), res(), want(k - 3));
            else chk($sformatf("stream_idle_%0d", k), {31'd0, out_valid}, 32'd0);
        end

        // Fill the pipe with out_ready low, then stall 5 cycles
        out_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            drive(8 + j);
            tick();
        end
        drive(12);
        chk("stall_full", res(), want(8));
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall_in_ready_%0d", c), {31'd0, in_ready}, 32'd0);
            tick();
            chk($sformatf("stall_hold_%0d", c), res(), want(8));
        end
        out_ready = 1'b1;
        #1;
        chk("stall_release_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("drain_1", res(), want(9));
        tick();
        chk("drain_2", res(), want(10));
        tick();
        chk("drain_3", res(), want(11));
        tick();
        chk("drain_4", res(), want(12));
        tick();
        chk("drain_empty", {31'd0, out_valid}, 32'd0);

        // Signed-overflow pair
        a = 16'h7FFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
        tick();
        a = 16'hFFFF; b = 16'h0001;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("ovf_case_sum", res(), {14'd0, 1'b1, 1'b0, 16'h8000});
`ifdef PIPELINED_RCA_OVF_EN
        chk("ovf_case_flag", {31'd0, ovf}, 32'd1);
`endif
        tick();
        chk("noovf_case_sum", res(), {14'd0, 1'b1, 1'b1, 16'h0000});
`ifdef PIPELINED_RCA_OVF_EN
        chk("noovf_case_flag", {31'd0, ovf}, 32'd0);
`endif
        tick();

        // Reset two cycles after accepting 1234+1111: the 2345 result must never appear
        a = 16'h1234; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_result", res(), 32'h0);
        tick();
        chk("midreset_hold", res(), 32'h0);
        tick();
        rst_n = 1'b1;
        a = 16'h0001; b = 16'h0002; cin = 1'b0; in_valid = 1'b1;
        chk("postreset_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            chk($sformatf("postreset_edge%0d", e), res(), 32'h0);
            tick();
        end
        chk("postreset_result", res(), {14'd0, 1'b1, 1'b0, 16'h0003});
        tick();
        chk("postreset_empty", res(), {14'd0, 1'b0, 1'b0, 16'h0003});

        // Exhaustive 4-bit sweep; STAGES=s delivers vector t on the loop pass t+s-1
        for (int t = 0; t < 515; t++) begin
            logic [8:0] v;
            v = 9'(t);
            if (t < 512) begin
                na = v[8:5]; nb = v[4:1]; ncin = v[0]; n_valid = 1'b1;
            end else begin
                n_valid = 1'b0;
            end
            tick();
            for (int st = 1; st <= 4; st *= 2) begin
                int         idx;
                logic [8:0] u;
                logic [4:0] ex;
                logic [5:0] got;
                idx = t - (st - 1);
                if (idx >= 0 && idx < 512) begin
                    u   = 9'(idx);
                    ex  = 5'(u[8:5]) + 5'(u[4:1]) + 5'(u[0]);
                    got = (st == 1) ? {n1_ov, n1_co, n1_s}
                        : (st == 2) ? {n2_ov, n2_co, n2_s} : {n4_ov, n4_co, n4_s};
                    chk($sformatf("w4_s%0d_vec%0d", st, idx), {26'd0, got}, {26'd0, 1'b1, ex});
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/pipelined_rca.md
PIPELINED_RCA -- requirements
Module: pipelined_rca

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand and sum width in bits.
REQ-002 SHALL have parameter STAGES, default 4, meaning the number of pipeline stages; each stage adds one chunk of CHUNK = WIDTH/STAGES bits.
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, meaning the asynchronous, active-low reset.
REQ-005 SHALL have port A, input, WIDTH bits, meaning operand A.
REQ-006 SHALL have port B, input, WIDTH bits, meaning operand B.
REQ-007 SHALL have port Cin, input, 1 bit, meaning the carry into bit 0.
REQ-008 SHALL have port in_valid, input, 1 bit, meaning A/B/Cin are valid.
REQ-009 SHALL have port in_ready, output, 1 bit, meaning the block accepts an operand set this cycle.
REQ-010 SHALL have port S, output, WIDTH bits, meaning the sum.
REQ-011 SHALL have port Cout, output, 1 bit, meaning the carry out of bit WIDTH-1.
REQ-012 SHALL have port out_valid, output, 1 bit, meaning S/Cout are valid.
REQ-013 SHALL have port out_ready, input, 1 bit, meaning the consumer accepts the result.

Function
REQ-014 SHALL form {Cout,S} = A + B + Cin modulo 2^(WIDTH+1), exact for all inputs.
REQ-015 SHALL accept an operand set on a rising edge when in_valid=1 and in_ready=1.
REQ-016 SHALL assert out_valid for an accepted set exactly STAGES rising edges after acceptance when no stall occurs.
REQ-017 SHALL have stage i add chunk i (bits i*CHUNK..i*CHUNK+CHUNK-1) using the carry registered by stage i-1, and SHALL carry the unused upper operand chunks and the finished lower sum chunks forward in registers.
REQ-018 SHALL advance all stages together under the common enable adv = !out_valid || out_ready.
REQ-019 SHALL drive in_ready = adv combinationally.
REQ-020 SHALL hold S, Cout and out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL propagate an invalid (bubble) stage when in_valid=0 on an advancing edge, without compressing bubbles.
REQ-022 SHALL sustain one result per cycle when in_valid=1 and out_ready=1 continuously.
REQ-023 SHALL accept a STAGES value of 1 and then behave as a registered full adder with a latency of 1.
REQ-024 SHALL flag, at elaboration, a WIDTH that is not divisible by STAGES as a fatal error.

Reset
REQ-025 SHALL, while rst_n=0, clear all stage valid bits, so that out_valid=0, and clear all data and carry registers to 0, so that S=0 and Cout=0.
REQ-026 SHALL discard every in-flight operand set when reset is asserted mid-operation, with no result emitted after release.
REQ-027 SHALL accept input again on the first rising edge after rst_n deasserts.

Configuration
REQ-028 SHALL, when PIPELINED_RCA_OVF_EN is defined, add output port OVF (1 bit) equal to the two's-complement signed overflow of A+B+Cin, aligned with S and reset to 0.
REQ-029 SHALL, when PIPELINED_RCA_OVF_EN is undefined, have no OVF port and no associated logic.

Structure
REQ-030 SHALL place in shared package rca_pkg the default WIDTH and STAGES constants and the stage-record typedef (valid, carry, partial sum, pending operand chunks).
REQ-031 SHALL implement the per-stage combinational chunk adder as sub-module rca_slice (parameter CHUNK; ports a, b, ci, s, co), built as a ripple of full-adder bits.

Verification
REQ-032 SHALL verify, with WIDTH=16 and STAGES=4, that A=0xFFFF, B=0x0001, Cin=0 gives S=0x0000, Cout=1 with out_valid high exactly 4 edges after acceptance.
REQ-033 SHALL verify that 8 back-to-back sets with out_ready=1 produce 8 consecutive correct results, one per cycle, in order.
REQ-034 SHALL verify that holding out_ready=0 for 5 cycles with a full pipe keeps in_ready=0, keeps S/Cout unchanged, and loses or duplicates no result.
REQ-035 SHALL verify that asserting rst_n=0 two cycles after accepting A=0x1234, B=0x1111 forces out_valid=0 immediately, and that no 0x2345 result ever appears.
REQ-036 SHALL verify, with WIDTH=4 and STAGES in {1,2,4}, all 512 {A,B,Cin} combinations against A+B+Cin.
REQ-037 SHALL verify, with PIPELINED_RCA_OVF_EN defined, that A=0x7FFF, B=0x0001, Cin=0 gives OVF=1 and S=0x8000, and that A=0xFFFF, B=0x0001 gives OVF=0.
